// File: rtl/mem_test_engine.sv
// mem_test_engine: two-pass PSRAM self-test (write pattern over a range, read back and compare) driving memCtrl.
module mem_test_engine #(
  parameter int          ADDR_W      = 24,
  parameter int          DATA_W      = 8,
  parameter logic [15:0] FIXED_PAT   = 16'h00AA,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          START_DELAY = 50000,
  parameter int          TIMEOUT     = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic              i_stopOnError,
  input  logic [ADDR_W-1:0] i_addrFirst,
  input  logic [ADDR_W-1:0] i_addrLast,
  output logic              o_cs,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_dataToWrite,
  input  logic [DATA_W-1:0] i_dataRead,
  input  logic              i_busy,
  input  logic              i_dataReady,
  output logic              o_running,
  output logic              o_done,
  output logic              o_pass,
  output logic [1:0]        o_errCode,
  output logic [ADDR_W-1:0] o_failAddr,
  output logic [DATA_W-1:0] o_failExp,
  output logic [DATA_W-1:0] o_failGot,
  output logic [15:0]       o_errCount,
  output logic [3:0]        o_state
);
  typedef enum logic [3:0] {IDLE, DELAY, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] addr, first, last, addr_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic [1:0] mode, err_nxt;
  logic stop, start_ok, bad_range, at_last, mism, in_wait, tmo_hit, chk_err, first_err, adv, rewind;
  logic [31:0] cnt;
  logic [DATA_W-1:0] rd_data;
  function automatic logic [DATA_W-1:0] pat_of(input logic [ADDR_W-1:0] a, input logic [15:0] l);
    return mode == 2'd0 ? FIXED_PAT[DATA_W-1:0] : mode == 2'd1 ? a[DATA_W-1:0] :
           mode == 2'd2 ? ~a[DATA_W-1:0] : l[DATA_W-1:0];
  endfunction
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction
  assign o_state = state;
  // Request states are the single o_cs-low cycle; predecessors only enter them once memCtrl is idle.
  always_comb begin
    start_ok = i_start && (state == IDLE || state == DONE);
    bad_range = i_addrFirst > i_addrLast;
    at_last = addr == last;
    mism = rd_data != pat_of(addr, lfsr);
    in_wait = state == WR_WAIT || state == RD_WAIT;
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nxt = bad_range ? DONE : DELAY;
      DELAY:   if (cnt >= 32'(START_DELAY) && !i_busy) state_nxt = WR_REQ;
      WR_REQ:  state_nxt = WR_WAIT;
      WR_WAIT: state_nxt = cnt != '0 && !i_busy ? (at_last ? RD_REQ : WR_REQ) :
                           cnt == 32'(TIMEOUT - 1) ? DONE : WR_WAIT;
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = cnt != '0 && i_dataReady && !i_busy ? CHECK :
                           cnt == 32'(TIMEOUT - 1) ? DONE : RD_WAIT;
      CHECK:   state_nxt = (mism && stop) || at_last ? DONE : !i_busy ? RD_REQ : CHECK;
      default: state_nxt = IDLE;
    endcase
    tmo_hit = in_wait && state_nxt == DONE;
    chk_err = state == CHECK && state_nxt != CHECK && mism;
    first_err = o_errCode == 2'd0 && (tmo_hit || chk_err);
    err_nxt = start_ok ? (bad_range ? 2'd3 : 2'd0) : first_err ? (tmo_hit ? 2'd2 : 2'd1) : o_errCode;
    rewind = state == WR_WAIT && state_nxt == RD_REQ;
    adv = (state == WR_WAIT && state_nxt == WR_REQ) || (state == CHECK && state_nxt == RD_REQ);
    addr_nxt = start_ok ? i_addrFirst : rewind ? first : adv ? addr + ADDR_W'(1) : addr;
    lfsr_nxt = start_ok || rewind ? LFSR_SEED : adv ? lfsr_step(lfsr) : lfsr;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_cs <= 1'b1;
      o_write <= 1'b0;
      o_address <= '0;
      o_dataToWrite <= '0;
      o_running <= 1'b0;
      o_done <= 1'b0;
      o_pass <= 1'b0;
      o_errCode <= '0;
      o_failAddr <= '0;
      o_failExp <= '0;
      o_failGot <= '0;
      o_errCount <= '0;
      addr <= '0;
      first <= '0;
      last <= '0;
      lfsr <= LFSR_SEED;
      mode <= '0;
      stop <= 1'b0;
      cnt <= '0;
      rd_data <= '0;
    end else begin
      addr <= addr_nxt;
      lfsr <= lfsr_nxt;
      o_errCode <= err_nxt;
      o_cs <= !(state_nxt == WR_REQ || state_nxt == RD_REQ);
      o_running <= !(state_nxt == IDLE || state_nxt == DONE);
      o_done <= state_nxt == DONE;
      o_pass <= state_nxt == DONE && err_nxt == 2'd0;
      cnt <= state == DELAY ? cnt + 32'(cnt < 32'(START_DELAY)) : in_wait ? cnt + 32'd1 : '0;
      if (state_nxt == WR_REQ || state_nxt == RD_REQ) begin
        o_write <= state_nxt == WR_REQ;
        o_address <= addr_nxt;
        o_dataToWrite <= pat_of(addr_nxt, lfsr_nxt);
      end
      if (start_ok) begin
        first <= i_addrFirst;
        last <= i_addrLast;
        mode <= i_mode;
        stop <= i_stopOnError;
        o_errCount <= '0;
        o_failAddr <= '0;
        o_failExp <= '0;
        o_failGot <= '0;
      end
      if (state == RD_WAIT && state_nxt == CHECK) rd_data <= i_dataRead;
      if (chk_err) o_errCount <= o_errCount + 16'(o_errCount != 16'hFFFF);
      // A timeout only records where it stalled; expected/read data stay cleared.
      if (first_err) begin
        o_failAddr <= addr;
        o_failExp <= tmo_hit ? '0 : pat_of(addr, lfsr);
        o_failGot <= tmo_hit ? '0 : rd_data;
      end
    end
endmodule
